// File: rtl/eth_rx_deframer.sv
// eth_rx_deframer: GMII receive deframer for the clk_phy domain.
// Strips preamble/SFD, checks CRC-32 residue and frame length, and emits the
// payload through a short delay line with an end-of-frame status pulse.
// Build option: ETH_RX_FCS_STRIP_EN removes the 4-byte FCS from the output
// stream (5-byte delay line); undefined forwards the FCS (1-byte delay line).
module eth_rx_deframer #(
    parameter int unsigned MIN_FRAME_LEN = 64,
    parameter int unsigned MAX_FRAME_LEN = 1518
) (
    input  logic        clk_phy,
    input  logic        rst_n_phy,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_err,
    input  logic [7:0]  gmii_rx_data,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        stat_valid,
    output logic        stat_good,
    output logic        stat_fcs_err,
    output logic        stat_len_err,
    output logic        stat_phy_err,
    output logic [10:0] stat_len
);

`ifdef ETH_RX_FCS_STRIP_EN
    localparam int unsigned DEPTH = 5;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned   FW          = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FULL        = FW'(DEPTH);
    localparam logic [31:0]   CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0]   MIN_LEN     = 11'(MIN_FRAME_LEN);
    localparam logic [10:0]   MAX_LEN     = 11'(MAX_FRAME_LEN);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t              state, state_next;
    logic [31:0]         crc;
    logic [10:0]         len_cnt;
    logic                phy_err;
    logic [FW-1:0]       fill;
    logic [DEPTH*8-1:0]  dly;
    logic [DEPTH*8-1:0]  dly_in;
    logic                sfd, data_byte, frame_end, full, fcs_err, len_err, emit;

    function automatic logic [31:0] crc_update(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Oldest byte lives in dly[7:0]; new bytes enter at the top.
    if (DEPTH > 1) begin : g_shift
        assign dly_in = {gmii_rx_data, dly[DEPTH*8-1:8]};
    end else begin : g_single
        assign dly_in = gmii_rx_data;
    end

    // Next-state decode and per-cycle frame events.
    always_comb begin
        state_next = state;
        sfd        = 1'b0;
        case (state)
            IDLE: begin
                if (gmii_rx_dv) state_next = (gmii_rx_data == 8'h55) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_next = IDLE;
                end else if (gmii_rx_err || (gmii_rx_data != 8'h55 && gmii_rx_data != 8'hD5)) begin
                    state_next = DROP;
                end else if (gmii_rx_data == 8'hD5) begin
                    state_next = DATA;
                    sfd        = 1'b1;
                end
            end
            DATA:    if (!gmii_rx_dv) state_next = IDLE;
            DROP:    if (!gmii_rx_dv) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        data_byte = (state == DATA) && gmii_rx_dv;
        frame_end = (state == DATA) && !gmii_rx_dv;
        full      = (fill == FULL);
        emit      = full && (data_byte || frame_end);
        fcs_err   = (crc != CRC_RESIDUE);
        len_err   = (len_cnt < MIN_LEN) || (len_cnt > MAX_LEN);
    end

    // State register.
    always_ff @(posedge clk_phy or negedge rst_n_phy) begin
        if (!rst_n_phy) state <= IDLE;
        else            state <= state_next;
    end

    // Per-frame accumulators: CRC, saturating length, sticky PHY error, delay line.
    always_ff @(posedge clk_phy or negedge rst_n_phy) begin
        if (!rst_n_phy) begin
            crc     <= '1;
            len_cnt <= '0;
            phy_err <= 1'b0;
            fill    <= '0;
            dly     <= '0;
        end else if (sfd) begin
            crc     <= '1;
            len_cnt <= '0;
            phy_err <= 1'b0;
            fill    <= '0;
        end else if (data_byte) begin
            crc <= crc_update(crc, gmii_rx_data);
            if (len_cnt != '1) len_cnt <= len_cnt + 11'd1;
            if (gmii_rx_err)   phy_err <= 1'b1;
            dly <= dly_in;
            if (!full) fill <= fill + FW'(1);
        end
    end

    // Registered output stream and end-of-frame status.
    always_ff @(posedge clk_phy or negedge rst_n_phy) begin
        if (!rst_n_phy) begin
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_last       <= 1'b0;
            stat_valid   <= 1'b0;
            stat_good    <= 1'b0;
            stat_fcs_err <= 1'b0;
            stat_len_err <= 1'b0;
            stat_phy_err <= 1'b0;
            stat_len     <= '0;
        end else begin
            m_valid      <= emit;
            m_last       <= full && frame_end;
            if (emit) m_data <= dly[7:0];
            stat_valid   <= frame_end;
            stat_good    <= frame_end && !(fcs_err || len_err || phy_err);
            stat_fcs_err <= frame_end && fcs_err;
            stat_len_err <= frame_end && len_err;
            stat_phy_err <= frame_end && phy_err;
            stat_len     <= frame_end ? len_cnt : '0;
        end
    end

endmodule
